// File: rtl/display_scanner.sv
// Time-multiplexed digit scanner for an 8-digit seven-segment display.
// It keeps a tear-free snapshot of the value and blanks every anode at the start of each digit slot.
module display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   ltr_mask_i,
  input  logic [NUM_DIGITS-1:0]   en_mask_i,
  input  logic                    load_i,
  output logic [3:0]              data_o,
  output logic                    ltr_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD_T   = TW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {GUARD, SHOW} state_t;

  state_t                         state, state_n;
  logic [TW-1:0]                  tick, tick_n;
  logic [IW-1:0]                  idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0]     act_val, act_val_n, pend_val;
  logic [NUM_DIGITS-1:0]          act_ltr, act_ltr_n, pend_ltr;
  logic [NUM_DIGITS-1:0]          act_en, act_en_n, pend_en;
  logic                           pend_v;
  logic                           slot_end, frame_end;

  assign slot_end  = (tick == TICK_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign tick_n    = slot_end ? '0 : tick + 1'b1;
  assign idx_n     = frame_end ? '0 : (slot_end ? idx + 1'b1 : idx);

  // The snapshot seen by the outputs only changes at frame wrap, so a frame never mixes two loads.
  always_comb begin
    act_val_n = act_val;
    act_ltr_n = act_ltr;
    act_en_n  = act_en;
    if (frame_end) begin
      if (load_i) begin
        act_val_n = value_i;
        act_ltr_n = ltr_mask_i;
        act_en_n  = en_mask_i;
      end else if (pend_v) begin
        act_val_n = pend_val;
        act_ltr_n = pend_ltr;
        act_en_n  = pend_en;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      GUARD: state_n = (tick_n >= GUARD_T) ? SHOW : GUARD;
      SHOW:  state_n = (slot_end && GUARD_CYCLES != 0) ? GUARD : SHOW;
      default: state_n = GUARD;
    endcase
  end

  // Outputs are computed from next-state values so they line up with tick/idx without extra lag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= GUARD;
      tick     <= '0;
      idx      <= '0;
      act_val  <= '0;
      act_ltr  <= '0;
      act_en   <= '0;
      pend_val <= '0;
      pend_ltr <= '0;
      pend_en  <= '0;
      pend_v   <= 1'b0;
      data_o   <= '0;
      ltr_o    <= 1'b0;
      an_o     <= '1;
      frame_o  <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      idx     <= idx_n;
      act_val <= act_val_n;
      act_ltr <= act_ltr_n;
      act_en  <= act_en_n;
      if (frame_end) begin
        pend_v <= 1'b0;
      end else if (load_i) begin
        pend_val <= value_i;
        pend_ltr <= ltr_mask_i;
        pend_en  <= en_mask_i;
        pend_v   <= 1'b1;
      end
      data_o  <= act_val_n[idx_n];
      ltr_o   <= act_ltr_n[idx_n];
      an_o    <= (state_n == SHOW && act_en_n[idx_n]) ? ~(NUM_DIGITS'(1) << idx_n) : '1;
      frame_o <= frame_end;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomized scoreboard bench for display_scanner: a time-based reference model predicts every output cycle.
// The monitor pops each prediction and compares it against the DUT.
module tb_display_scanner;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FRAME = N * RD;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [15:0]   value_i = '0;
  logic [3:0]    ltr_mask_i = '0;
  logic [3:0]    en_mask_i = '0;
  logic          load_i = 1'b0;
  logic [3:0]    data_o;
  logic          ltr_o;
  logic [3:0]    an_o;
  logic          frame_o;

  display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .value_i(value_i), .ltr_mask_i(ltr_mask_i),
    .en_mask_i(en_mask_i), .load_i(load_i), .data_o(data_o), .ltr_o(ltr_o),
    .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] data;
    logic       ltr;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: time since reset decides slot and phase; snapshots swap at each frame boundary.
  int          m_t = 0;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_ltr = '0, m_en = '0, p_ltr = '0, p_en = '0;
  bit          p_v = 0;

  always @(posedge clk_i) begin
    exp_t e;
    int   slot, tk;
    if (rst_i) begin
      m_t = 0; m_val = '0; m_ltr = '0; m_en = '0;
      p_val = '0; p_ltr = '0; p_en = '0; p_v = 0;
      e = '{data: 4'h0, ltr: 1'b0, an: 4'hF, frame: 1'b0};
    end else begin
      if ((m_t % FRAME) == FRAME - 1) begin
        if (load_i) begin
          m_val = value_i; m_ltr = ltr_mask_i; m_en = en_mask_i;
        end else if (p_v) begin
          m_val = p_val; m_ltr = p_ltr; m_en = p_en;
        end
        p_v = 0;
      end else if (load_i) begin
        p_val = value_i; p_ltr = ltr_mask_i; p_en = en_mask_i; p_v = 1;
      end
      m_t++;
      slot = (m_t / RD) % N;
      tk   = m_t % RD;
      e.data  = m_val[4*slot +: 4];
      e.ltr   = m_ltr[slot];
      e.an    = (tk >= G && m_en[slot]) ? 4'(~(4'b0001 << slot)) : 4'hF;
      e.frame = (slot == 0 && tk == 0);
    end
    exp_q.push_back(e);
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h, expected %0h", name, m_t, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("data_o",  8'(data_o),  8'(e.data));
      checkOutput("ltr_o",   8'(ltr_o),   8'(e.ltr));
      checkOutput("an_o",    8'(an_o),    8'(e.an));
      checkOutput("frame_o", 8'(frame_o), 8'(e.frame));
    end
  end

  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                               input logic [3:0] lm, input logic [3:0] em);
    @(negedge clk_i);
    #1;
    rst_i = r; load_i = l; value_i = v; ltr_mask_i = lm; en_mask_i = em;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Idles until the upcoming clock edge lands on the given position within the frame.
  task automatic waitPhase(input int phase);
    int k;
    k = 0;
    while ((m_t % FRAME) != phase && k < 2 * FRAME) begin
      idle(1);
      k++;
    end
    checks++;
    if ((m_t % FRAME) != phase) begin
      errors++;
      $display("[TB] FAIL phase_wait: got %0d, expected %0d", m_t % FRAME, phase);
    end
  endtask

  initial begin
    $display("[TB] display_scanner scoreboard bench");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(FRAME);

    waitPhase(4);
    applyStimulus(1'b0, 1'b1, 16'h4321, 4'h0, 4'hF);
    idle(2 * FRAME);

    waitPhase(3);
    applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF);
    idle(5);
    applyStimulus(1'b0, 1'b1, 16'h2222, 4'h0, 4'hF);
    idle(2 * FRAME);

    waitPhase(FRAME - 1);
    applyStimulus(1'b0, 1'b1, 16'h5A00, 4'h0, 4'hF);
    idle(FRAME);

    waitPhase(6);
    applyStimulus(1'b0, 1'b1, 16'h0A05, 4'b0100, 4'b0101);
    idle(2 * FRAME);

    waitPhase(3);
    applyStimulus(1'b0, 1'b1, 16'h9876, 4'hF, 4'hF);
    waitPhase(2 * RD + 5);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(2 * FRAME);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                    16'($urandom), 4'($urandom), 4'($urandom));
    end
    idle(FRAME);

    @(negedge clk_i);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed digit scanner that sits directly upstream of the seven-segment decoder on the Nexys-style 8-digit display. Holds a tear-free snapshot of the value to show and steps through the digits at a fixed refresh rate. Each step presents one nibble plus its letter flag to the decoder's `data_i`/`ltr_i` and drives the matching active-low anode. A short all-anodes-off guard at the start of every digit slot suppresses ghosting while the decoder output settles.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned; legal range 2–8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `GUARD_CYCLES`, 1000: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- Reset is synchronous and active-high; the block has one clock, `clk_i`.
- `clk_i` input 1: system clock.
- `rst_i` input 1: synchronous, active-high reset.
- `value_i` input 4*NUM_DIGITS: digit nibbles; digit k is `value_i[4k+3:4k]`, digit 0 is rightmost.
- `ltr_mask_i` input NUM_DIGITS: per-digit letter flag; bit k is forwarded as `ltr_o` for digit k.
- `en_mask_i` input NUM_DIGITS: per-digit enable; 0 means the digit is never lit.
- `load_i` input 1: single-cycle strobe that captures `value_i`, `ltr_mask_i` and `en_mask_i`.
- `data_o` output 4: nibble for the current digit; goes to the decoder's `data_i`.
- `ltr_o` output 1: letter flag for the current digit; goes to the decoder's `ltr_i`.
- `an_o` output NUM_DIGITS: anode enables, active-low; at most one bit is low.
- `frame_o` output 1: one-cycle pulse when the scan restarts at digit 0.

## Operation
- Registers:
  - `tick` runs 0..REFRESH_DIV-1.
  - `idx` runs 0..NUM_DIGITS-1.
  - An active snapshot holds value, ltr and en.
  - A pending snapshot holds the same fields, plus a `pend_v` flag.
- State machine, two states:
  - GUARD: `tick < GUARD_CYCLES`.
  - SHOW: the remainder of the slot.
  - GUARD → SHOW when `tick` reaches `GUARD_CYCLES`. SHOW → GUARD when `tick` wraps to 0.
- Slot advance: when `tick == REFRESH_DIV-1`, `tick` goes to 0 and `idx` increments. `idx` wraps from NUM_DIGITS-1 to 0.
- `load_i`: copies the inputs into the pending snapshot and sets `pend_v`. Repeated loads overwrite; the last load wins.
- Snapshot swap happens only at frame wrap, i.e. the cycle with `idx == NUM_DIGITS-1` and `tick == REFRESH_DIV-1`:
  - If `pend_v` is set, pending is copied to active and `pend_v` is cleared.
  - If `load_i` is high on that same cycle, the live inputs go straight to active and `pend_v` ends cleared.
  - As a result, a displayed frame never mixes two loads.
- `data_o`/`ltr_o` carry the active nibble and flag of `idx` for the whole slot, including GUARD. This gives the decoder the guard time to settle.
- `an_o`:
  - All ones in GUARD.
  - In SHOW, bit `idx` is low, but only if active `en[idx]` = 1; otherwise all ones.
- `frame_o` is high for exactly the one cycle in which `idx` = 0 and `tick` = 0, excluding the first cycle after reset.
- Reset values:
  - `tick` = 0, `idx` = 0, state GUARD.
  - Active and pending snapshots = 0, `pend_v` = 0.
  - `data_o` = 0, `ltr_o` = 0, `an_o` = all ones, `frame_o` = 0.
- Reset mid-slot or mid-frame aborts immediately and discards any pending load. The frame after reset shows zeros with all digits disabled until a load is swapped in.

## Timing
- All outputs are registered and update on the same edge as `tick`/`idx`, so there is no extra lag between `idx` and the outputs.
- Slot period = `REFRESH_DIV` cycles. Frame period = `NUM_DIGITS*REFRESH_DIV` cycles.
- Per slot, `an_o` has exactly `GUARD_CYCLES` cycles all-ones, then `REFRESH_DIV-GUARD_CYCLES` cycles with one bit low.
- Load-to-display latency:
  - Minimum 1 cycle, when the load coincides with the wrap cycle.
  - Maximum `NUM_DIGITS*REFRESH_DIV` cycles.
- `frame_o` pulses coincide with the first GUARD cycle of digit 0.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
- **Reset:** assert `rst_i` for 3 cycles, then release → `an_o` = 4'b1111, `data_o` = 0, `ltr_o` = 0, `frame_o` = 0. No anode goes low during the first frame (32 cycles).
- **Basic load and scan:** pulse `load_i` with `value_i` = 16'h4321, `en_mask_i` = 4'b1111, `ltr_mask_i` = 0 during frame 0 → next frame shows `data_o` = 1,2,3,4 in slots 0..3. `an_o` is 1110, 1101, 1011, 0111 for cycles 2–7 of each slot and 1111 for cycles 0–1. `frame_o` pulses once per 32 cycles.
- **Tear-free:** load 16'h1111, then, within the same frame, load 16'h2222 → the next frame shows all 2s and no frame mixes 1s and 2s.
- **Wrap-cycle load:** `load_i` with 16'h5A00 exactly on the cycle with `idx` = 3, `tick` = 7 → on the very next cycle the active snapshot holds 16'h5A00 and `pend_v` = 0.
- **Masks:** `en_mask_i` = 4'b0101, `ltr_mask_i` = 4'b0100, `value_i` = 16'h0A05 → `an_o` stays 1111 in slots 1 and 3. Slot 2 has `data_o` = 4'hA with `ltr_o` = 1; slot 0 has `data_o` = 5 with `ltr_o` = 0.
- **Reset mid-frame:** assert `rst_i` at `idx` = 2, `tick` = 5 with `pend_v` set → outputs return to reset values on the next edge and the pending load is never displayed.
